// File: rtl/mant_mul_seq.sv
// mant_mul_seq: sequential shift-add multiplier for unsigned FP significands.
// Takes two WIDTH-bit mantissas (hidden bit restored) and returns the raw
// 2*WIDTH-bit product to the rounding stage. It uses a valid/ready handshake on
// both sides and handles one operation at a time.
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as no multiplier
// bits remain. Latency then depends on the operand instead of always being WIDTH cycles.
module mant_mul_seq #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_mant_a,
    input  logic [WIDTH-1:0]     i_mant_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   ma;
    logic [WIDTH-1:0]     mb;
    logic [CNT_W-1:0]     cnt;

    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mb_next;
    logic                 last_step;

    // One shift-add step: the partial sum, the shifted multiplier, and whether this edge ends the operation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        acc_next  = acc;
        mb_next   = mb >> 1;
        last_step = 1'b0;
        if (mb[0]) begin
            // Cannot wrap: the product of two WIDTH-bit values fits in 2*WIDTH bits.
            acc_next = acc + ma;
        end
`ifdef MUL_EARLY_EXIT_EN
        // No multiplier bits left, so the remaining steps would only add zero.
        last_step = (cnt == CNT_W'(WIDTH - 1)) || (mb_next == '0);
`else
        last_step = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    // Control FSM and datapath registers. All outputs are registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_product <= '0;
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
            cnt       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register here sees pre-edge values.
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        // The operands are captured only here. Later input changes are ignored.
                        ma      <= {{WIDTH{1'b0}}, i_mant_a};
                        mb      <= i_mant_b;
                        acc     <= '0;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    ma  <= ma << 1;
                    mb  <= mb_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        o_product <= acc_next;
                        o_valid   <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Hold the result until the consumer takes it. The next accept waits for IDLE.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
